// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
package div_sched_pkg;

   // Operand widths of the shared divider: 8-bit dividend, 4-bit divisor.
   localparam int DW = 8;
   localparam int VW = 4;

   // Scheduler states; the encoding is also what dbg_state exposes.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Response error codes carried on rsp_err.
   typedef logic [1:0] err_t;
   localparam err_t ERR_OK   = 2'b00;
   localparam err_t ERR_DIV0 = 2'b01;
   localparam err_t ERR_OVF  = 2'b10;
   localparam err_t ERR_TMO  = 2'b11;

   // The quotient fits in VW bits only when the dividend's upper VW bits are
   // strictly below the divisor.
   function automatic logic quotient_overflows(input logic [DW-1:0] dividend,
                                               input logic [VW-1:0] divisor);
      return dividend[DW-1 -: VW] >= divisor;
   endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N. Produces a one-hot grant, its index and an any flag.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] idx,
   output logic           any
);

   logic [IDW-1:0] cand;

   // Scan N candidates starting at ptr; the first requester found wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = IDW'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one 8/4 sequential divider among N
// requesters. One transaction is in flight at a time; operands are screened
// for divide-by-zero and quotient overflow before the divider is started.
//
// Handshakes: gnt is a single-cycle accept pulse (operands sampled in that
// cycle). The response channel is valid/ready: once rsp_valid rises, every
// rsp_* output holds stable until the cycle in which rsp_ready is high, and
// that edge is the transfer. div_start is a one-cycle pulse; the divider is
// considered finished when div_ready returns high after having been seen low.
module div_sched
   import div_sched_pkg::*;
#(
   parameter int N       = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic [8*N-1:0]  req_dividend,
   input  logic [4*N-1:0]  req_divisor,
   output logic [N-1:0]    gnt,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [IDW-1:0]  rsp_id,
   output logic [3:0]      rsp_quotient,
   output logic [3:0]      rsp_remainder,
   output logic [1:0]      rsp_err,
   output logic            div_start,
   output logic [7:0]      div_word1,
   output logic [3:0]      div_word2,
   input  logic [3:0]      div_quotient,
   input  logic [3:0]      div_remainder,
   input  logic            div_ready,
   output logic [1:0]      dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [DW-1:0]   op_a;
   logic [VW-1:0]   op_b;
   logic            busy_seen;
   logic [CW-1:0]   wait_cnt;

   logic [N-1:0]    arb_grant;
   logic [IDW-1:0]  arb_idx;
   logic            arb_any;
   logic            grant_ok;
   logic [DW-1:0]   sel_a;
   logic [VW-1:0]   sel_b;
   logic [IDW-1:0]  next_ptr;

   rr_arbiter #(
      .N   (N),
      .IDW (IDW)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // A grant happens only from IDLE and only while the divider is idle.
   assign grant_ok  = (state == ST_IDLE) && arb_any && div_ready;
   assign gnt       = grant_ok ? arb_grant : '0;
   assign next_ptr  = (arb_idx == IDW'(N - 1)) ? '0 : arb_idx + IDW'(1);

   // The divider always sees the latched operands; they only move on a grant.
   assign div_word1 = op_a;
   assign div_word2 = op_b;
   assign dbg_state = state;

   // Mux the winning requester's operand slices.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N; i++) begin
         if (arb_grant[i]) begin
            sel_a = req_dividend[DW*i +: DW];
            sel_b = req_divisor[VW*i +: VW];
         end
      end
   end

   // Scheduler FSM: accept, screen, start the divider, wait, respond.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         op_a          <= '0;
         op_b          <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_err       <= ERR_OK;
         div_start     <= 1'b0;
         busy_seen     <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         div_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_ok) begin
                  op_a          <= sel_a;
                  op_b          <= sel_b;
                  rsp_id        <= arb_idx;
                  ptr           <= next_ptr;
                  rsp_quotient  <= '0;
                  rsp_remainder <= '0;
                  if (sel_b == '0) begin
                     rsp_err   <= ERR_DIV0;
                     rsp_valid <= 1'b1;
                     state     <= ST_RESP;
                  end else if (quotient_overflows(sel_a, sel_b)) begin
                     rsp_err   <= ERR_OVF;
                     rsp_valid <= 1'b1;
                     state     <= ST_RESP;
                  end else begin
                     div_start <= 1'b1;
                     state     <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               busy_seen <= 1'b0;
               wait_cnt  <= '0;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt + CW'(1);
               if (!div_ready) begin
                  busy_seen <= 1'b1;
               end
               // Completion needs the busy phase to have been observed, so a
               // divider that has not yet reacted to start is not mistaken
               // for a finished one.
               if (div_ready && busy_seen) begin
                  rsp_quotient  <= div_quotient;
                  rsp_remainder <= div_remainder;
                  rsp_err       <= ERR_OK;
                  rsp_valid     <= 1'b1;
                  state         <= ST_RESP;
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  rsp_quotient  <= '0;
                  rsp_remainder <= '0;
                  rsp_err       <= ERR_TMO;
                  rsp_valid     <= 1'b1;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: vector table for single transactions plus
// hand-written round-robin, backpressure, timeout and mid-flight reset cases.
module tb_div_sched;
   import div_sched_pkg::*;

   localparam int N       = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 15;
   localparam int W       = 12;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [8*N-1:0]  req_dividend;
   logic [4*N-1:0]  req_divisor;
   logic [N-1:0]    gnt;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IDW-1:0]  rsp_id;
   logic [3:0]      rsp_quotient;
   logic [3:0]      rsp_remainder;
   logic [1:0]      rsp_err;
   logic            div_start;
   logic [7:0]      div_word1;
   logic [3:0]      div_word2;
   logic [3:0]      div_quotient;
   logic [3:0]      div_remainder;
   logic            div_ready;
   logic [1:0]      dbg_state;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;

   typedef struct {
      int         id;
      logic [7:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      logic [1:0] err;
      int         lat;
      int         starts;
   } vec_t;

   vec_t vecs[10];

   div_sched #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .gnt           (gnt),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_quotient  (rsp_quotient),
      .rsp_remainder (rsp_remainder),
      .rsp_err       (rsp_err),
      .div_start     (div_start),
      .div_word1     (div_word1),
      .div_word2     (div_word2),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .div_ready     (div_ready),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- divider model ----------------
   // Four busy cycles after start; div_hang keeps it busy indefinitely.
   logic       dv_busy;
   logic [2:0] dv_cnt;
   logic [3:0] dv_q;
   logic [3:0] dv_r;
   logic       div_hang = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dv_busy <= 1'b0;
         dv_cnt  <= '0;
         dv_q    <= '0;
         dv_r    <= '0;
      end else if (!dv_busy) begin
         if (div_start) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 3'd4;
            dv_q    <= 4'(div_word1 / div_word2);
            dv_r    <= 4'(div_word1 % div_word2);
         end
      end else if (dv_cnt > 3'd1) begin
         dv_cnt <= dv_cnt - 3'd1;
      end else if (!div_hang) begin
         dv_busy <= 1'b0;
      end
   end

   assign div_ready     = !dv_busy;
   assign div_quotient  = dv_q;
   assign div_remainder = dv_r;

   // ---------------- helpers / driver tasks ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [N-1:0] g);
      int r = -1;
      int n = 0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) begin
            r = i;
            n++;
         end
      end
      return (n == 1) ? r : -1;
   endfunction

   task automatic set_req(input int id, input logic [7:0] a, input logic [3:0] b);
      req[id]                 = 1'b1;
      req_dividend[8*id +: 8] = a;
      req_divisor[4*id +: 4]  = b;
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      req       = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 300; c++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      #1;
      check("drain_pending", exp_q.size(), 0);
   endtask

   // One request from an idle scheduler; cycle 0 is the cycle req rises.
   task automatic run_single(input vec_t v);
      int gc = -1;
      int sc = -1;
      int rc = -1;
      int starts = 0;
      logic [N-1:0] gv = '0;
      logic [7:0]   w1 = '0;
      logic [3:0]   w2 = '0;
      exp_q.push_back({2'(v.id), v.q, v.r, v.err});
      set_req(v.id, v.a, v.b);
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (gnt != '0 && gc < 0) begin
            gc = c;
            gv = gnt;
         end
         if (div_start) begin
            starts++;
            if (sc < 0) begin
               sc = c;
               w1 = div_word1;
               w2 = div_word2;
            end
         end
         if (rsp_valid && rc < 0) rc = c;
         @(posedge clk);
         #1;
         if (gc >= 0) req = '0;
         if (rc >= 0) break;
      end
      check("gnt_cycle", gc, 0);
      check("gnt_onehot", int'(gv), 1 << v.id);
      check("rsp_latency", rc, v.lat);
      check("start_count", starts, v.starts);
      if (v.starts > 0) begin
         check("start_cycle", sc, 1);
         check("div_word1", int'(w1), int'(v.a));
         check("div_word2", int'(w2), int'(v.b));
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d err %0d expected no response",
                     rsp_id, rsp_err);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_id", int'(rsp_id), int'(mon_e[11:10]));
            check("rsp_quotient", int'(rsp_quotient), int'(mon_e[9:6]));
            check("rsp_remainder", int'(rsp_remainder), int'(mon_e[5:2]));
            check("rsp_err", int'(rsp_err), int'(mon_e[1:0]));
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int order[5];
      int gcyc[5];
      int ng;
      int exp_order[5];
      vec_t tmo;
      vec_t after_rst;

      // id, dividend, divisor, q, r, err, rsp latency, div_start count
      vecs[0] = '{1, 8'd100, 4'd7,  4'd14, 4'd2, ERR_OK,   7, 1};
      vecs[1] = '{2, 8'd42,  4'd0,  4'd0,  4'd0, ERR_DIV0, 1, 0};
      vecs[2] = '{0, 8'hF0,  4'd4,  4'd0,  4'd0, ERR_OVF,  1, 0};
      vecs[3] = '{3, 8'd42,  4'd3,  4'd14, 4'd0, ERR_OK,   7, 1};
      vecs[4] = '{0, 8'd255, 4'd0,  4'd0,  4'd0, ERR_DIV0, 1, 0};
      vecs[5] = '{1, 8'h3F,  4'd4,  4'd15, 4'd3, ERR_OK,   7, 1};
      vecs[6] = '{2, 8'h40,  4'd4,  4'd0,  4'd0, ERR_OVF,  1, 0};
      vecs[7] = '{3, 8'd0,   4'd9,  4'd0,  4'd0, ERR_OK,   7, 1};
      vecs[8] = '{0, 8'h7F,  4'd15, 4'd8,  4'd7, ERR_OK,   7, 1};
      vecs[9] = '{1, 8'hFF,  4'd15, 4'd0,  4'd0, ERR_OVF,  1, 0};

      reset        = 1'b1;
      req          = '0;
      req_dividend = '0;
      req_divisor  = '0;
      rsp_ready    = 1'b1;
      #2;
      check("reset_outputs",
            int'({rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
                  gnt, div_start, div_word1, div_word2}), 0);
      check("reset_state", int'(dbg_state), int'(ST_IDLE));
      apply_reset();

      // Table-driven single transactions.
      for (int i = 0; i < 10; i++) begin
         run_single(vecs[i]);
      end
      wait_drain();

      // Round robin with every requester active from a reset pointer.
      apply_reset();
      exp_order = '{0, 1, 2, 3, 0};
      exp_q.push_back({2'd0, 4'd6, 4'd2, ERR_OK});
      exp_q.push_back({2'd1, 4'd7, 4'd0, ERR_OK});
      exp_q.push_back({2'd2, 4'd7, 4'd1, ERR_OK});
      exp_q.push_back({2'd3, 4'd7, 4'd2, ERR_OK});
      exp_q.push_back({2'd0, 4'd6, 4'd2, ERR_OK});
      for (int i = 0; i < N; i++) set_req(i, 8'(20 + i), 4'd3);
      ng = 0;
      for (int c = 0; c < 100 && ng < 5; c++) begin
         @(negedge clk);
         if (gnt != '0) begin
            order[ng] = onehot_idx(gnt);
            gcyc[ng]  = c;
            ng++;
         end
         @(posedge clk);
         #1;
         if (ng == 5) req = '0;
      end
      req = '0;
      check("rr_grant_count", ng, 5);
      for (int k = 0; k < ng; k++) begin
         check("rr_order", order[k], exp_order[k]);
         if (k > 0) check("rr_spacing", gcyc[k] - gcyc[k-1], 8);
      end
      wait_drain();

      // Backpressure: response held with another request pending.
      rsp_ready = 1'b0;
      exp_q.push_back({2'd2, 4'd0, 4'd0, ERR_DIV0});
      exp_q.push_back({2'd3, 4'd6, 4'd0, ERR_OK});
      set_req(2, 8'd42, 4'd0);
      @(negedge clk);
      check("bp_gnt", int'(gnt), 4);
      @(posedge clk);
      #1;
      req = '0;
      set_req(3, 8'd30, 4'd5);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_hold", int'({rsp_valid, rsp_id, rsp_err, rsp_quotient, gnt}),
               int'({1'b1, 2'd2, ERR_DIV0, 4'd0, 4'b0000}));
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_handshake_gnt", int'(gnt), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_next_gnt", int'(gnt), 8);
      @(posedge clk);
      #1;
      req = '0;
      wait_drain();

      // Divider never completes: timeout after TIMEOUT cycles in WAIT.
      div_hang = 1'b1;
      tmo = '{0, 8'd100, 4'd7, 4'd0, 4'd0, ERR_TMO, 2 + TIMEOUT, 1};
      run_single(tmo);
      @(negedge clk);
      check("tmo_back_to_idle", int'({dbg_state, rsp_valid}), int'({ST_IDLE, 1'b0}));
      div_hang = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      wait_drain();

      // Reset while waiting on the divider abandons the transaction.
      set_req(1, 8'd100, 4'd7);
      @(negedge clk);
      check("rst_gnt", int'(gnt), 2);
      @(posedge clk);
      #1;
      req = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_wait", int'(dbg_state), int'(ST_WAIT));
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rst_async_outputs",
            int'({rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
                  gnt, div_start, div_word1, div_word2}), 0);
      check("rst_async_state", int'(dbg_state), int'(ST_IDLE));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      after_rst = '{2, 8'd42, 4'd3, 4'd14, 4'd0, ERR_OK, 7, 1};
      run_single(after_rst);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Round-robin scheduler that shares one 8-bit / 4-bit sequential divider unit among N requesters.
- Accepts one request at a time and pre-screens operands for divide-by-zero and quotient overflow.
- Sequences the divider's start/ready handshake and returns the result with the requester ID over a valid/ready response channel.
- Sits between client blocks and the single shared divider instance.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester ID width; equals ceil(log2(N)).
- TIMEOUT, 15, maximum cycles spent in WAIT before the timeout error is reported.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-requester request level; held until granted.
- req_dividend  in  8*N  packed dividends; requester i uses bits [8i+7:8i].
- req_divisor  in  4*N  packed divisors; requester i uses bits [4i+3:4i].
- gnt  out  N  one-hot, single-cycle accept pulse; operands are sampled in this cycle.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_quotient  out  4  quotient.
- rsp_remainder  out  4  remainder.
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 overflow, 11 timeout.
- div_start  out  1  start pulse to the divider.
- div_word1  out  8  dividend to the divider.
- div_word2  out  4  divisor to the divider.
- div_quotient  in  4  divider quotient.
- div_remainder  in  4  divider remainder.
- div_ready  in  1  divider idle; low while iterating.

Behaviour:
- Reset (async) forces all of the following to 0: state=IDLE, rr pointer, latched operands, rsp_* outputs, gnt, div_start, busy_seen, wait counter.
- Reset mid-operation abandons the transaction with no response. The divider shares the same reset.

State machine IDLE / ISSUE / WAIT / RESP:
- IDLE:
  - If req is nonzero and div_ready=1, pick the winner: the first set req bit searching from ptr upward, wrapping mod N.
  - gnt[winner]=1 combinationally in that cycle. Latch dividend, divisor and ID at the edge, and set ptr=(winner+1) mod N.
  - If divisor==0, go to RESP with err=01.
  - Else if dividend[7:4] >= divisor, go to RESP with err=10 (quotient would not fit in 4 bits).
  - Otherwise go to ISSUE.
  - If div_ready=0 in IDLE, nothing is granted.
- ISSUE:
  - div_start=1 for exactly one cycle; div_word1/div_word2 driven from the latched operands.
  - Clear busy_seen and the wait counter, then go to WAIT.
- WAIT:
  - div_start=0.
  - div_ready=0 sets busy_seen.
  - On div_ready=1 with busy_seen=1: capture div_quotient/div_remainder, err=00, go to RESP.
  - The wait counter increments every cycle. If it reaches TIMEOUT before completion, go to RESP with err=11, quotient=0 and remainder=0.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - The handshake edge returns to IDLE with rsp_valid=0.
  - No grant can occur in the same cycle as the handshake.
- div_word1/div_word2 keep the latched values outside ISSUE; they change only when a new grant is made.

Latency, grant at cycle 0 with the standard divider (4 iteration cycles):
- div_start at cycle 1.
- div_ready low during cycles 2-5, high at cycle 6.
- rsp_valid at cycle 7.
- Error bypass (err 01 or 10): rsp_valid at cycle 1.

Fairness and holding:
- Requester i, once it is pending, waits at most N-1 other grants.
- A single requester that keeps requesting is granted back-to-back, one grant per transaction.
- req changes while a transaction is in flight are ignored until IDLE.
- Operands must be stable only during the gnt cycle.

Decomposition:
- Package div_sched_pkg:
  - State encoding localparams ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP.
  - Error codes ERR_OK/ERR_DIV0/ERR_OVF/ERR_TMO.
  - Operand widths DW=8, VW=4.
- Sub-module rr_arbiter:
  - Combinational round-robin pick from req and ptr.
  - Outputs a one-hot grant and an encoded index.

Test Plan:
- Single request, requester 1, 100/7 -> gnt[1] at cycle 0, div_start at cycle 1, rsp_valid at cycle 7 with id=1, q=14, r=2, err=00.
- Requester 2, 42/0 -> no div_start; rsp_valid at cycle 1 with err=01, id=2. Requester 0, 0xF0/4 -> err=10, no div_start.
- req=4'b1111 held, rsp_ready tied 1 -> grant order 0,1,2,3,0; each requester gets one grant per four transactions.
- rsp_ready held 0 for 5 cycles with a pending request -> rsp_* stable, no gnt. Releasing rsp_ready -> next grant one cycle after the handshake.
- Divider model that never raises div_ready after start -> rsp_valid with err=11 after TIMEOUT cycles in WAIT, then the scheduler returns to IDLE.
- reset asserted during WAIT -> all outputs 0 immediately, state IDLE. After release, a new 42/3 request returns q=14, r=0.
